// File: rtl/alu_md.sv
// alu_md -- EX-stage ALU with an iterative multiply/divide unit.
//
// Purpose:
//   Combinational ALU (add, sub, and, or, nor, xor, slt, HI/LO read) plus a
//   multi-cycle unit that fills the HI/LO result registers. The multiply is
//   shift-add. The divide is restoring shift-subtract. Each takes WIDTH
//   cycles. Signed operations run on operand magnitudes, and the unit fixes
//   the result signs in the final step.
//
// Optional feature:
//   ALU_MD_DIV_EN -- when defined, the divide codes 1010 (div) and 1011 (divu)
//   are built. When undefined there is no divider logic, and start with those
//   codes is ignored.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high
//   ctl    in   [3:0] operation select
//   a, b   in   [WIDTH-1:0] operands
//   start  in   launch the multiply/divide selected by ctl
//   out    out  [WIDTH-1:0] combinational result
//   z      out  out == 0
//   busy   out  multiply/divide in progress
//   done   out  one-cycle pulse, HI/LO just updated
//   hi, lo out  [WIDTH-1:0] result registers
//
// Handshake:
//   start is sampled only when the unit is not running (IDLE or DONE) and
//   ctl holds an enabled multi-cycle code. On that edge a, b and the op are
//   latched. busy is high for exactly WIDTH cycles. done then pulses for one
//   cycle, and during that cycle hi/lo already hold the result. A start in
//   the done cycle is accepted. A start while busy is dropped.

module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // acc: mult upper partial product / div partial remainder
  // q  : mult multiplier shifting out, product low half shifting in /
  //      div dividend shifting out, quotient bits shifting in
  // m  : multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;    // negate product / quotient at the end
`ifdef ALU_MD_DIV_EN
  logic             div_q, div_d;    // current op is a divide
  logic             rneg_q, rneg_d;  // remainder takes the negative dividend sign
`endif

  // ---------------------------------------------------------------- decode
  logic             is_mul, is_div_code, accept, sgn_op;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_mul = (ctl == 4'b1000) || (ctl == 4'b1001);
`ifdef ALU_MD_DIV_EN
  assign is_div_code = (ctl == 4'b1010) || (ctl == 4'b1011);
`else
  assign is_div_code = 1'b0;
`endif
  assign accept = start && (state_q != S_RUN) && (is_mul || is_div_code);
  // 1000 (mult) and 1010 (div) are the signed codes.
  assign sgn_op = ~ctl[0];
  // The magnitude of MIN is 2^(WIDTH-1), which still fits as unsigned.
  assign a_mag  = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn_op && b[WIDTH-1]) ? -b : b;

  // ------------------------------------------------------------ datapath step
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   acc_step, q_step;
  logic [2*WIDTH-1:0] prod;

  assign mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);

`ifdef ALU_MD_DIV_EN
  logic [WIDTH:0] rem_sh, trial;
  assign rem_sh = {acc_q, q_q[WIDTH-1]};
  // Bit WIDTH of trial is set exactly when the shifted remainder is below the
  // divisor. A zero divisor never restores, which yields an all-ones quotient
  // and a remainder equal to the dividend.
  assign trial  = rem_sh - {1'b0, m_q};

  always_comb begin
    if (div_q) begin
      if (trial[WIDTH]) begin
        acc_step = rem_sh[WIDTH-1:0];
        q_step   = {q_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_step = trial[WIDTH-1:0];
        q_step   = {q_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step = mul_sum[WIDTH:1];
      q_step   = {mul_sum[0], q_q[WIDTH-1:1]};
    end
  end
`else
  assign acc_step = mul_sum[WIDTH:1];
  assign q_step   = {mul_sum[0], q_q[WIDTH-1:1]};
`endif

  assign prod = sgn_q ? -{acc_step, q_step} : {acc_step, q_step};

  // ---------------------------------------------------- FSM next state / data
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
`ifdef ALU_MD_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      S_RUN: begin
        acc_d = acc_step;
        q_d   = q_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
`ifdef ALU_MD_DIV_EN
          if (div_q) begin
            lo_d = sgn_q  ? -q_step   : q_step;
            hi_d = rneg_q ? -acc_step : acc_step;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = state_q;
    endcase

    if (accept) begin
      state_d = S_RUN;
      acc_d   = '0;
      q_d     = a_mag;
      m_d     = b_mag;
      cnt_d   = '0;
      // A zero divisor keeps the quotient at all ones whatever the signs.
      // For a multiply by zero, negating a zero product changes nothing.
      sgn_d   = sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
`ifdef ALU_MD_DIV_EN
      div_d   = is_div_code;
      rneg_d  = sgn_op && a[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
`ifdef ALU_MD_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
`ifdef ALU_MD_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // ------------------------------------------------------- combinational ALU
  logic [WIDTH-1:0] diff;
  logic             slt_bit;

  assign diff    = a + ~b + ONE;
  // Signed overflow occurs when the operand signs differ and the difference
  // sign differs from a. In that case the difference sign is inverted.
  assign slt_bit = diff[WIDTH-1] ^ ((a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]));

  always_comb begin
    case (ctl)
      4'b0010: out = a + b;
      4'b0110: out = diff;
      4'b0000: out = a & b;
      4'b0001: out = a | b;
      4'b1100: out = ~(a | b);
      4'b1101: out = a ^ b;
      4'b0111: out = {{(WIDTH-1){1'b0}}, slt_bit};
      4'b0011: out = hi_q;
      4'b0100: out = lo_q;
      default: out = '0;
    endcase
  end

  assign z = (out == '0);

endmodule
